// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
//
// Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring shift-subtract), one
// step per cycle for WIDTH cycles, followed by a sign-fix cycle that writes
// HI/LO. MTHI/MTLO write HI/LO directly while the unit is idle.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous, active-high reset
//   start_i        request a new operation (sampled only in idle)
//   op_i           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data_i      operand A (multiplicand / dividend)
//   rt_data_i      operand B (multiplier / divisor)
//   hi_we_i        MTHI write enable
//   lo_we_i        MTLO write enable
//   wr_data_i      MTHI/MTLO write data
//   busy_o         operation in progress
//   done_o         one-cycle pulse when HI/LO receive a result
//   div_by_zero_o  qualifies done_o; divisor was zero
//   hi_o           HI register (product high / remainder)
//   lo_o           LO register (product low / quotient)
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_data_i,
    input  logic [WIDTH-1:0] rt_data_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             state_q;
    logic [1:0]         op_q;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   opnd_q;   // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]   a_raw_q;  // raw dividend, returned in HI on divide by zero
    logic               b_zero_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    // Operand magnitudes at the start edge; op_i[0]=0 selects the signed ops.
    logic             in_sign_a;
    logic             in_sign_b;
    logic [WIDTH-1:0] in_mag_a;
    logic [WIDTH-1:0] in_mag_b;

    always_comb begin
        in_sign_a = ~op_i[0] & rs_data_i[WIDTH-1];
        in_sign_b = ~op_i[0] & rt_data_i[WIDTH-1];
        in_mag_a  = in_sign_a ? (~rs_data_i + 1'b1) : rs_data_i;
        in_mag_b  = in_sign_b ? (~rt_data_i + 1'b1) : rt_data_i;
    end

    // One iteration of the selected algorithm.
    // Multiply: acc = {partial high, remaining multiplier bits}; add then shift right.
    // Divide:   acc = {remainder, dividend/quotient bits}; shift left then trial subtract.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH + 1){1'b0}});
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
        acc_d     = acc_q;
        if (op_q[1]) begin
            if (!div_diff[WIDTH+1]) begin
                acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign correction applied in the fix cycle.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_dbz;

    always_comb begin
        prod    = acc_q;
        quo     = acc_q[WIDTH-1:0];
        rem     = acc_q[2*WIDTH-1:WIDTH];
        res_hi  = '0;
        res_lo  = '0;
        res_dbz = 1'b0;
        if (op_q[1]) begin
            if (!op_q[0]) begin
                if (sign_a_q ^ sign_b_q) begin
                    quo = ~acc_q[WIDTH-1:0] + 1'b1;
                end
                if (sign_a_q) begin
                    rem = ~acc_q[2*WIDTH-1:WIDTH] + 1'b1;
                end
            end
            if (b_zero_q) begin
                res_hi  = a_raw_q;
                res_lo  = '1;
                res_dbz = 1'b1;
            end else begin
                res_hi = rem;
                res_lo = quo;
            end
        end else begin
            if (!op_q[0] && (sign_a_q ^ sign_b_q)) begin
                prod = ~acc_q + 1'b1;
            end
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            op_q     <= 2'b00;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            b_zero_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        op_q     <= op_i;
                        a_raw_q  <= rs_data_i;
                        b_zero_q <= (rt_data_i == '0);
                        sign_a_q <= in_sign_a;
                        sign_b_q <= in_sign_b;
                        if (op_i[1]) begin
                            acc_q  <= {{WIDTH{1'b0}}, in_mag_a};
                            opnd_q <= in_mag_b;
                        end else begin
                            acc_q  <= {{WIDTH{1'b0}}, in_mag_b};
                            opnd_q <= in_mag_a;
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StCalc;
                    end else begin
                        // MTHI/MTLO only when no operation is being accepted.
                        if (hi_we_i) begin
                            hi_q <= wr_data_i;
                        end
                        if (lo_we_i) begin
                            lo_q <= wr_data_i;
                        end
                    end
                end
                StCalc: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    done_q  <= 1'b1;
                    dbz_q   <= res_dbz;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule
